z80_cb_idx_exec: RTL and testbench

Z80_CB_IDX_EXEC -- requirements
Module: z80_cb_idx_exec

---
 rtl/z80_cb_idx_exec.sv | 171 +++++++++++++++++
 tb/tb_z80_cb_idx_exec.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/z80_cb_idx_exec.sv
// Executes one DDCB/FDCB (IX/IY+d) CB-page operation: computes EA, reads the
// operand, applies rotate/shift/BIT/RES/SET and writes back with timeout abort.
module z80_cb_idx_exec #(
   parameter int ADDR_W     = 16,
   parameter bit UNDOC_COPY = 1'b1,
   parameter int MAX_WAIT   = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        op,
   input  logic [ADDR_W-1:0] base,
   input  logic [7:0]        disp,
   input  logic [7:0]        flags_in,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        result,
   output logic [2:0]        res_reg,
   output logic              res_reg_we,
   output logic [7:0]        flags_out,
   output logic              flags_we,
   output logic              done,
   output logic              abort
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_WR   = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam int              CNT_W    = $clog2(MAX_WAIT + 2);
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

   logic [2:0]              state;
   logic [7:0]              op_q;
   logic [7:0]              flags_q;
   logic [7:0]              rdata_q;
   logic [7:0]              result_q;
   logic [7:0]              flags_out_q;
   logic [ADDR_W-1:0]       ea_q;
   logic [CNT_W-1:0]        wait_cnt;
   logic                    abort_q;
   logic signed [ADDR_W-1:0] disp_sx;
   logic [ADDR_W-1:0]       ea_calc;
   logic [8:0]              rot;
   logic [7:0]              exec_res;
   logic [7:0]              exec_flags;
   logic                    is_bit;
   logic                    copy_ok;

   // Returns {carry_out, result}; sel is op[5:3] of the CB rotate/shift group.
   function automatic logic [8:0] rot_shift(input logic [2:0] sel, input logic [7:0] m,
                                            input logic cin);
      case (sel)
         3'd0:    return {m[7], m[6:0], m[7]};
         3'd1:    return {m[0], m[0], m[7:1]};
         3'd2:    return {m[7], m[6:0], cin};
         3'd3:    return {m[0], cin, m[7:1]};
         3'd4:    return {m[7], m[6:0], 1'b0};
         3'd5:    return {m[0], m[7], m[7:1]};
         3'd6:    return {m[7], m[6:0], 1'b1};
         default: return {m[0], 1'b0, m[7:1]};
      endcase
   endfunction

   // Flag layout is S Z Y H X P N C from bit 7 down to bit 0.
   function automatic logic [7:0] rs_flags(input logic [7:0] r, input logic c);
      return {r[7], (r == 8'h00), r[5], 1'b0, r[3], ~^r, 1'b0, c};
   endfunction

   function automatic logic [7:0] bit_flags(input logic [7:0] m, input logic [2:0] b,
                                            input logic y, input logic x, input logic c);
      logic z;
      z = ~m[b];
      return {(b == 3'd7) & m[7], z, y, 1'b1, x, z, 1'b0, c};
   endfunction

   assign disp_sx = {{(ADDR_W-8){disp[7]}}, disp};
   assign ea_calc = base + $unsigned(disp_sx);
   assign is_bit  = (op_q[7:6] == 2'b01);
   assign copy_ok = UNDOC_COPY && !is_bit && (op_q[2:0] != 3'd6);

   always_comb begin
      exec_res   = rdata_q;
      exec_flags = flags_q;
      rot        = rot_shift(op_q[5:3], rdata_q, flags_q[0]);
      case (op_q[7:6])
         2'b00: begin
            exec_res   = rot[7:0];
            exec_flags = rs_flags(rot[7:0], rot[8]);
         end
         2'b01:   exec_flags = bit_flags(rdata_q, op_q[5:3], ea_q[13], ea_q[11], flags_q[0]);
         2'b10:   exec_res   = rdata_q & ~(8'h01 << op_q[5:3]);
         default: exec_res   = rdata_q | (8'h01 << op_q[5:3]);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         op_q        <= '0;
         flags_q     <= '0;
         rdata_q     <= '0;
         result_q    <= '0;
         flags_out_q <= '0;
         ea_q        <= '0;
         wait_cnt    <= '0;
         abort_q     <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               op_q    <= op;
               flags_q <= flags_in;
               ea_q    <= ea_calc;
               state   <= S_ADDR;
            end
            S_ADDR: begin
               wait_cnt <= '0;
               state    <= S_RD;
            end
            S_RD: if (mem_ack) begin
               rdata_q  <= mem_rdata;
               wait_cnt <= '0;
               state    <= S_EXEC;
            end else if (wait_cnt == WAIT_LIM) begin
               abort_q <= 1'b1;
               state   <= S_IDLE;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
            S_EXEC: begin
               result_q    <= exec_res;
               flags_out_q <= exec_flags;
               wait_cnt    <= '0;
               state       <= is_bit ? S_DONE : S_WR;
            end
            S_WR: if (mem_ack) begin
               state <= S_DONE;
            end else if (wait_cnt == WAIT_LIM) begin
               abort_q <= 1'b1;
               state   <= S_IDLE;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy       = (state != S_IDLE);
   assign mem_addr   = busy ? ea_q : '0;
   assign mem_rd     = (state == S_RD);
   assign mem_wr     = (state == S_WR);
   assign mem_wdata  = mem_wr ? result_q : 8'h00;
   assign result     = result_q;
   assign flags_out  = flags_out_q;
   assign res_reg    = op_q[2:0];
   assign done       = (state == S_DONE);
   assign flags_we   = done & ~op_q[7];
   assign res_reg_we = done & copy_ok;
   assign abort      = abort_q;

endmodule

// File: tb/tb_z80_cb_idx_exec.sv
// Bench for z80_cb_idx_exec: directed cases plus random ops against an
// arithmetic reference model, with a memory responder of programmable latency.
module tb_z80_cb_idx_exec;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  op = '0;
   logic [15:0] base = '0;
   logic [7:0]  disp = '0;
   logic [7:0]  flags_in = '0;
   logic        busy, mem_rd, mem_wr, res_reg_we, flags_we, done, abort;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, result, flags_out;
   logic [7:0]  mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [2:0]  res_reg;

   always #5 clk = ~clk;

   z80_cb_idx_exec dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .base(base), .disp(disp),
      .flags_in(flags_in), .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .result(result), .res_reg(res_reg), .res_reg_we(res_reg_we), .flags_out(flags_out),
      .flags_we(flags_we), .done(done), .abort(abort)
   );

   logic [7:0] mem [65536];
   int rd_delay = 0, wr_delay = 0, rd_cnt = 0, wr_cnt = 0, wr_count = 0;
   bit both_seen = 1'b0;
   int vectors = 0, miscompares = 0;

   // Memory responder: ack after the programmed number of wait cycles.
   always @(negedge clk) begin
      if (mem_rd && mem_wr) both_seen = 1'b1;
      if (mem_rd) begin
         mem_ack   = (rd_cnt == rd_delay);
         mem_rdata = mem[mem_addr];
         rd_cnt++;
      end else if (mem_wr) begin
         mem_ack = (wr_cnt == wr_delay);
         wr_cnt++;
      end else begin
         mem_ack = 1'b0;
         rd_cnt  = 0;
         wr_cnt  = 0;
      end
   end

   always @(posedge clk) begin
      if (reset_n && mem_wr && mem_ack) begin
         mem[mem_addr] = mem_wdata;
         wr_count++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int calc_ea(input int b, input int d);
      int sd;
      sd = (d >= 128) ? d - 256 : d;
      return (b + sd + 65536) % 65536;
   endfunction

   function automatic void model(input int opv, input int m, input int fin, input int ea,
                                 output int r, output int fo, output bit fwe,
                                 output bit rwe, output bit wr);
      int grp, b, c, ones, bitv;
      grp = opv / 64;
      b   = (opv / 8) % 8;
      r = m; fo = fin; fwe = 1'b0; wr = 1'b1; c = 0;
      rwe = (grp != 1) && (opv % 8 != 6);
      case (grp)
         0: begin
            case (b)
               0: begin c = m / 128; r = (m * 2) % 256 + c; end
               1: begin c = m % 2;   r = m / 2 + c * 128; end
               2: begin c = m / 128; r = (m * 2) % 256 + fin % 2; end
               3: begin c = m % 2;   r = m / 2 + (fin % 2) * 128; end
               4: begin c = m / 128; r = (m * 2) % 256; end
               5: begin c = m % 2;   r = m / 2 + (m / 128) * 128; end
               6: begin c = m / 128; r = (m * 2) % 256 + 1; end
               default: begin c = m % 2; r = m / 2; end
            endcase
            ones = 0;
            for (int i = 0; i < 8; i++) ones += (r >> i) % 2;
            fo = ((r >= 128) ? 128 : 0) + ((r == 0) ? 64 : 0) + (r % 64 / 32) * 32
                 + (r % 16 / 8) * 8 + ((ones % 2 == 0) ? 4 : 0) + c;
            fwe = 1'b1;
         end
         1: begin
            bitv = (m >> b) % 2;
            fo = ((b == 7 && bitv == 1) ? 128 : 0) + ((bitv == 0) ? 68 : 0) + 16
                 + ((ea / 8192) % 2) * 32 + ((ea / 2048) % 2) * 8 + fin % 2;
            fwe = 1'b1;
            wr  = 1'b0;
         end
         2: r = m - (((m >> b) % 2) << b);
         default: r = m + ((1 - (m >> b) % 2) << b);
      endcase
   endfunction

   task automatic run(input int opv, input int bv, input int dv, input int fin, input int mv,
                      input int rdd, input int wrd, input bit dbl);
      int ea, r, fo, cyc, w0, lat;
      bit fwe, rwe, wr;
      ea = calc_ea(bv, dv);
      mem[16'(ea)] = 8'(mv);
      model(opv, mv, fin, ea, r, fo, fwe, rwe, wr);
      lat = wr ? 5 + rdd + wrd : 4 + rdd;
      rd_delay = rdd; wr_delay = wrd; w0 = wr_count;
      op = 8'(opv); base = 16'(bv); disp = 8'(dv); flags_in = 8'(fin); start = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      check("ea", 32'(mem_addr), 32'(ea));
      check("busy", 32'(busy), 32'd1);
      while (!done && !abort && cyc < 60) begin
         start = (dbl && cyc == 2);
         if (dbl && cyc == 2) begin op = ~op; base = ~base; end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check("done", 32'(done), 32'd1);
      check("latency", 32'(cyc), 32'(lat));
      check("flags_we", 32'(flags_we), 32'(fwe));
      check("res_reg_we", 32'(res_reg_we), 32'(rwe));
      if (rwe) check("res_reg", 32'(res_reg), 32'(opv % 8));
      if (wr) check("result", 32'(result), 32'(r));
      if (fwe) check("flags_out", 32'(flags_out), 32'(fo));
      @(posedge clk); #1;
      check("done_pulse", 32'({done, busy}), 32'd0);
      check("mem", 32'(mem[16'(ea)]), 32'(wr ? r : mv));
      check("wr_count", 32'(wr_count - w0), 32'(wr ? 1 : 0));
      if (dbl) begin
         repeat (10) @(posedge clk);
         #1;
         check("dbl_idle", 32'(busy), 32'd0);
         check("dbl_writes", 32'(wr_count - w0), 32'(wr ? 1 : 0));
      end
   endtask

   task automatic run_abort(input int opv, input int bv, input int mv, input int rdd,
                            input int wrd, input int exp_cyc);
      int ea, cyc, w0;
      bit saw;
      ea = calc_ea(bv, 0);
      mem[16'(ea)] = 8'(mv);
      rd_delay = rdd; wr_delay = wrd; w0 = wr_count; saw = 1'b0;
      op = 8'(opv); base = 16'(bv); disp = 8'h00; flags_in = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!abort && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (done || flags_we || res_reg_we) saw = 1'b1;
      end
      check("abort", 32'(abort), 32'd1);
      check("abort_cycle", 32'(cyc), 32'(exp_cyc));
      check("abort_strobes", 32'({saw, busy, mem_rd, mem_wr}), 32'd0);
      @(posedge clk); #1;
      check("abort_pulse", 32'(abort), 32'd0);
      check("abort_mem", 32'(mem[16'(ea)]), 32'(mv));
      check("abort_writes", 32'(wr_count - w0), 32'd0);
   endtask

   initial begin
      int w0, cyc;
      #1 reset_n = 1'b0;
      #2;
      check("reset_ctl", 32'({busy, mem_rd, mem_wr, done, abort, flags_we, res_reg_we,
                              res_reg, result, flags_out}), 32'd0);
      check("reset_bus", 32'({mem_addr, mem_wdata}), 32'd0);
      @(posedge clk); @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk); #1;

      run('h15, 'h2d7b, 'h17, 'h64, 'h12, 0, 0, 1'b0);
      run('hC6, 'h0005, 'hFE, 'h00, 'h40, 0, 0, 1'b0);
      run('h1E, 'hFFFF, 'h01, 'h01, 'h81, 0, 0, 1'b0);
      run('h7E, 'h2800, 'h00, 'h01, 'h80, 0, 0, 1'b0);
      run('h46, 'h0000, 'h80, 'h00, 'h00, 0, 0, 1'b0);
      run('h15, 'h2d7b, 'h17, 'h64, 'h12, 3, 2, 1'b0);
      run('h3F, 'h1234, 'h7F, 'h00, 'h01, 15, 15, 1'b0);
      run('h87, 'h4000, 'h10, 'hFF, 'hFF, 1, 0, 1'b1);
      run_abort('h06, 'h3000, 'h5A, 1000, 0, 18);
      run_abort('hC0, 'h3100, 'h00, 0, 1000, 20);

      // Reset asserted while the write strobe is pending.
      mem[16'h5000] = 8'h33;
      rd_delay = 0; wr_delay = 1000; w0 = wr_count;
      op = 8'h00; base = 16'h5000; disp = 8'h00; flags_in = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!mem_wr && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("wr_reached", 32'(mem_wr), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midwr_ctl", 32'({busy, mem_rd, mem_wr, done, abort, flags_we, res_reg_we,
                              res_reg, result, flags_out}), 32'd0);
      check("midwr_bus", 32'({mem_addr, mem_wdata}), 32'd0);
      @(posedge clk); @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      check("midwr_mem", 32'(mem[16'h5000]), 32'h33);
      check("midwr_writes", 32'(wr_count - w0), 32'd0);
      run('h15, 'h2d7b, 'h17, 'h64, 'h12, 0, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         run(int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'b0);
      end

      check("rd_wr_overlap", 32'(both_seen), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
